grey_count_decoder: RTL and testbench

Receive-side decoder for the team's two-digit reflected counter code. Each decimal digit is carried as a 5-bit one-step code:
0=00000, 1=00001, 2=00011, 3=00010, 4=00110, 5=00100, 6=01100, 7=01000, 8=11000, 9=10000.
The block samples the 10-bit code bus (tens + ones) on a valid strobe, decodes both digits to BCD and checks that each sample is the +1 (mod 100) successor of the previous one. It reports lock status and error flags, and sits between the counter pins and the checker/display logic.

---
 rtl/grey_count_decoder_pkg.sv | 50 +++++
 rtl/grey_count_decoder_if.sv | 30 +++
 rtl/grey_count_decoder_digit_dec.sv | 19 +
 rtl/grey_count_decoder.sv | 150 +++++++++++++++
 tb/tb_grey_count_decoder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/grey_count_decoder_pkg.sv
// Shared definitions for the two-digit reflected counter code decoder:
// digit code table, digit/code types, lock FSM states and the digit decoder.
package grey_code_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [4:0] code_t;

  localparam code_t CODE_0 = 5'b00000;
  localparam code_t CODE_1 = 5'b00001;
  localparam code_t CODE_2 = 5'b00011;
  localparam code_t CODE_3 = 5'b00010;
  localparam code_t CODE_4 = 5'b00110;
  localparam code_t CODE_5 = 5'b00100;
  localparam code_t CODE_6 = 5'b01100;
  localparam code_t CODE_7 = 5'b01000;
  localparam code_t CODE_8 = 5'b11000;
  localparam code_t CODE_9 = 5'b10000;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } state_t;

  typedef struct packed {
    digit_t digit;
    logic   legal;
  } dec_t;

  // Map one 5-bit code to its decimal digit; any code outside the table is illegal.
  function automatic dec_t decode_digit(input code_t code);
    dec_t r;
    r.digit = '0;
    r.legal = 1'b1;
    case (code)
      CODE_0:  r.digit = 4'd0;
      CODE_1:  r.digit = 4'd1;
      CODE_2:  r.digit = 4'd2;
      CODE_3:  r.digit = 4'd3;
      CODE_4:  r.digit = 4'd4;
      CODE_5:  r.digit = 4'd5;
      CODE_6:  r.digit = 4'd6;
      CODE_7:  r.digit = 4'd7;
      CODE_8:  r.digit = 4'd8;
      CODE_9:  r.digit = 4'd9;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/grey_count_decoder_if.sv
// Code bus in, decoded digits and status out, between the counter pins
// (master side) and the decoder (slave side).
interface grey_count_decoder_if
  import grey_code_pkg::*;
#(
  parameter int unsigned ERR_W = 8
);

  logic             i_valid;
  code_t            i_code_ones;
  code_t            i_code_tens;
  logic             o_valid;
  digit_t           o_ones;
  digit_t           o_tens;
  logic             o_code_err;
  logic             o_step_err;
  logic             o_locked;
  logic [ERR_W-1:0] o_err_count;

  modport master (
    output i_valid, i_code_ones, i_code_tens,
    input  o_valid, o_ones, o_tens, o_code_err, o_step_err, o_locked, o_err_count
  );

  modport slave (
    input  i_valid, i_code_ones, i_code_tens,
    output o_valid, o_ones, o_tens, o_code_err, o_step_err, o_locked, o_err_count
  );

endinterface

// File: rtl/grey_count_decoder_digit_dec.sv
// Single-digit decoder: 5-bit reflected code to BCD digit plus legal flag.
module grey_digit_dec
  import grey_code_pkg::*;
(
  input  code_t  i_code,
  output digit_t o_digit,
  output logic   o_legal
);

  dec_t dec;

  // Pure table lookup, no state.
  always_comb begin
    dec     = decode_digit(i_code);
    o_digit = dec.digit;
    o_legal = dec.legal;
  end

endmodule

// File: rtl/grey_count_decoder.sv
// Two-digit reflected counter code decoder with +1 (mod 100) sequence lock.
// Optional error counter built only when GREY_DEC_ERRCNT_EN is defined;
// otherwise o_err_count is tied to zero.
module grey_count_decoder
  import grey_code_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  grey_count_decoder_if.slave  bus
);

  digit_t ones_d, tens_d;
  logic   ones_legal, tens_legal;

  grey_digit_dec u_ones_dec (
    .i_code  (bus.i_code_ones),
    .o_digit (ones_d),
    .o_legal (ones_legal)
  );

  grey_digit_dec u_tens_dec (
    .i_code  (bus.i_code_tens),
    .o_digit (tens_d),
    .o_legal (tens_legal)
  );

  state_t     state_q, state_n;
  logic [3:0] run_q, run_n;
  logic [6:0] prev_q, prev_n;
  logic       prev_ok_q, prev_ok_n;
  logic       valid_q, valid_n;
  digit_t     ones_q, ones_n;
  digit_t     tens_q, tens_n;
  logic       code_err_q, code_err_n;
  logic       step_err_q, step_err_n;

  logic [6:0] value;
  logic [6:0] expected;
  logic [3:0] run_inc;

  // Sample value, its expected successor-of-previous, and the incremented run.
  always_comb begin
    value    = 7'(tens_d) * 7'd10 + 7'(ones_d);
    expected = (prev_q == 7'd99) ? '0 : prev_q + 7'd1;
    run_inc  = run_q + 4'd1;
  end

  // Next-state and next-output logic for the lock FSM.
  always_comb begin
    state_n    = state_q;
    run_n      = run_q;
    prev_n     = prev_q;
    prev_ok_n  = prev_ok_q;
    ones_n     = ones_q;
    tens_n     = tens_q;
    valid_n    = 1'b0;
    code_err_n = 1'b0;
    step_err_n = 1'b0;
    if (bus.i_valid) begin
      valid_n = 1'b1;
      if (!(ones_legal && tens_legal)) begin
        code_err_n = 1'b1;
        state_n    = UNLOCKED;
        run_n      = '0;
        prev_ok_n  = 1'b0;
      end else begin
        ones_n    = ones_d;
        tens_n    = tens_d;
        prev_n    = value;
        prev_ok_n = 1'b1;
        case (state_q)
          UNLOCKED: begin
            if (prev_ok_q && (value == expected)) begin
              if (run_inc == 4'(LOCK_COUNT)) begin
                state_n = LOCKED;
                run_n   = '0;
              end else begin
                run_n = run_inc;
              end
            end else begin
              run_n = '0;
            end
          end
          LOCKED: begin
            if (value != expected) begin
              step_err_n = 1'b1;
              state_n    = UNLOCKED;
              run_n      = '0;
            end
          end
          default: state_n = UNLOCKED;
        endcase
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= UNLOCKED;
      run_q      <= '0;
      prev_q     <= '0;
      prev_ok_q  <= 1'b0;
      valid_q    <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
      code_err_q <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      run_q      <= run_n;
      prev_q     <= prev_n;
      prev_ok_q  <= prev_ok_n;
      valid_q    <= valid_n;
      ones_q     <= ones_n;
      tens_q     <= tens_n;
      code_err_q <= code_err_n;
      step_err_q <= step_err_n;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_ones     = ones_q;
  assign bus.o_tens     = tens_q;
  assign bus.o_code_err = code_err_q;
  assign bus.o_step_err = step_err_q;
  assign bus.o_locked   = (state_q == LOCKED);

`ifdef GREY_DEC_ERRCNT_EN
  logic [ERR_W-1:0] err_count_q;

  // Counts at the same edge the error flags are registered, so the count
  // moves in step with the visible flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_count_q <= '0;
    end else if ((code_err_n || step_err_n) && (err_count_q != '1)) begin
      err_count_q <= err_count_q + ERR_W'(1);
    end
  end

  assign bus.o_err_count = err_count_q;
`else
  assign bus.o_err_count = {ERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_grey_count_decoder.sv
// Self-checking bench for grey_count_decoder: behavioural model plus
// directed and randomized stimulus.
module tb_grey_count_decoder;

  localparam int unsigned ERR_W      = 8;
  localparam int          LOCK_COUNT = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  grey_count_decoder_if #(.ERR_W(ERR_W)) bus ();

  grey_count_decoder #(.LOCK_COUNT(LOCK_COUNT), .ERR_W(ERR_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [4:0] code_tab [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110,
                                5'b00100, 5'b01100, 5'b01000, 5'b11000, 5'b10000};

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int m_valid, m_ones, m_tens, m_code_err, m_step_err, m_locked, m_errcnt;
  int m_prev, m_prev_ok, m_run;

  function automatic int lookup(input logic [4:0] c);
    for (int d = 0; d < 10; d++) if (code_tab[d] == c) return d;
    return -1;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_valid = 0; m_ones = 0; m_tens = 0; m_code_err = 0; m_step_err = 0;
      m_locked = 0; m_errcnt = 0; m_prev = 0; m_prev_ok = 0; m_run = 0;
    end else begin
      int d_o, d_t, v, e;
      m_valid = bus.i_valid ? 1 : 0;
      m_code_err = 0;
      m_step_err = 0;
      if (bus.i_valid) begin
        d_o = lookup(bus.i_code_ones);
        d_t = lookup(bus.i_code_tens);
        if (d_o < 0 || d_t < 0) begin
          m_code_err = 1; m_locked = 0; m_run = 0; m_prev_ok = 0;
        end else begin
          v = d_t * 10 + d_o;
          e = (m_prev + 1) % 100;
          m_ones = d_o;
          m_tens = d_t;
          if (m_locked != 0) begin
            if (v != e) begin m_step_err = 1; m_locked = 0; m_run = 0; end
          end else if (m_prev_ok != 0 && v == e) begin
            m_run++;
            if (m_run == LOCK_COUNT) begin m_locked = 1; m_run = 0; end
          end else begin
            m_run = 0;
          end
          m_prev = v;
          m_prev_ok = 1;
        end
`ifdef GREY_DEC_ERRCNT_EN
        if ((m_code_err != 0 || m_step_err != 0) && m_errcnt < (1 << ERR_W) - 1) m_errcnt++;
`endif
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge i_clk) begin
    if (!i_rst) begin
      chk("valid",     32'(bus.o_valid),     32'(m_valid));
      chk("ones",      32'(bus.o_ones),      32'(m_ones));
      chk("tens",      32'(bus.o_tens),      32'(m_tens));
      chk("code_err",  32'(bus.o_code_err),  32'(m_code_err));
      chk("step_err",  32'(bus.o_step_err),  32'(m_step_err));
      chk("locked",    32'(bus.o_locked),    32'(m_locked));
      chk("err_count", 32'(bus.o_err_count), 32'(m_errcnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic [4:0] ct, input logic [4:0] co);
    @(negedge i_clk); #1;
    bus.i_valid = v; bus.i_code_tens = ct; bus.i_code_ones = co;
    @(posedge i_clk); #1;
  endtask

  task automatic stepv(input int val);
    step(1'b1, code_tab[val / 10], code_tab[val % 10]);
  endtask

  function automatic logic [4:0] illegal_code();
    logic [4:0] c;
    for (int t = 0; t < 100; t++) begin
      c = 5'($urandom_range(0, 31));
      if (lookup(c) < 0) return c;
    end
    return 5'b00101;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int base_err, cur, r;
    bus.i_valid = 1'b0; bus.i_code_ones = '0; bus.i_code_tens = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid",  32'(bus.o_valid),     0);
    chk("rst_locked", 32'(bus.o_locked),    0);
    chk("rst_ones",   32'(bus.o_ones),      0);
    chk("rst_errcnt", 32'(bus.o_err_count), 0);
    @(negedge i_clk); #1; i_rst = 1'b0;

    // Seed at 00 and lock after four legal steps.
    for (int k = 0; k <= 4; k++) begin
      stepv(k);
      chk("seq_ones", 32'(bus.o_ones), 32'(k));
      chk("seq_valid", 32'(bus.o_valid), 1);
      if (k == 3) chk("not_yet_locked", 32'(bus.o_locked), 0);
    end
    chk("locked_5th", 32'(bus.o_locked), 1);

    // Run through the 99 -> 00 wrap while locked.
    for (int k = 5; k <= 97; k++) stepv(k);
    stepv(98);
    chk("w98_tens", 32'(bus.o_tens), 9); chk("w98_ones", 32'(bus.o_ones), 8);
    stepv(99);
    chk("w99_tens", 32'(bus.o_tens), 9); chk("w99_ones", 32'(bus.o_ones), 9);
    stepv(0);
    chk("w00_tens", 32'(bus.o_tens), 0); chk("w00_ones", 32'(bus.o_ones), 0);
    chk("w00_locked", 32'(bus.o_locked), 1);
    chk("w00_step_err", 32'(bus.o_step_err), 0);

    // Skip from 37 to 39: step error, then relock needs four more steps.
    for (int k = 1; k <= 37; k++) stepv(k);
    stepv(39);
    chk("skip_step_err", 32'(bus.o_step_err), 1);
    chk("skip_locked", 32'(bus.o_locked), 0);
    chk("skip_ones", 32'(bus.o_ones), 9);
    for (int k = 40; k <= 42; k++) begin
      stepv(k);
      chk("relock_wait", 32'(bus.o_locked), 0);
    end
    stepv(43);
    chk("relocked", 32'(bus.o_locked), 1);

    // Illegal ones code while locked at 52.
    for (int k = 44; k <= 52; k++) stepv(k);
    base_err = int'(bus.o_err_count);
    step(1'b1, code_tab[5], 5'b00101);
    chk("ill_code_err", 32'(bus.o_code_err), 1);
    chk("ill_step_err", 32'(bus.o_step_err), 0);
    chk("ill_ones", 32'(bus.o_ones), 2);
    chk("ill_tens", 32'(bus.o_tens), 5);
    chk("ill_locked", 32'(bus.o_locked), 0);
`ifdef GREY_DEC_ERRCNT_EN
    chk("ill_errcnt", 32'(bus.o_err_count), 32'(base_err + 1));
`else
    chk("ill_errcnt", 32'(bus.o_err_count), 32'(base_err));
`endif

    // Alternate-cycle valid: gaps hold outputs, lock still reached.
    for (int k = 60; k <= 64; k++) begin
      stepv(k);
      step(1'b0, code_tab[0], code_tab[0]);
      chk("gap_valid", 32'(bus.o_valid), 0);
      chk("gap_ones", 32'(bus.o_ones), 32'(k % 10));
    end
    chk("gap_locked", 32'(bus.o_locked), 1);

    // Async reset mid-run: outputs clear before any clock edge.
    stepv(65);
    @(negedge i_clk); #2;
    i_rst = 1'b1;
    #1;
    chk("arst_valid",  32'(bus.o_valid),  0);
    chk("arst_ones",   32'(bus.o_ones),   0);
    chk("arst_tens",   32'(bus.o_tens),   0);
    chk("arst_locked", 32'(bus.o_locked), 0);
    chk("arst_errcnt", 32'(bus.o_err_count), 0);
    @(negedge i_clk); #1; i_rst = 1'b0;

    // Randomized mix of steps, jumps, gaps and illegal codes.
    cur = int'($urandom_range(0, 99));
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15) begin
        step(1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end else if (r < 19) begin
        if (r < 17) step(1'b1, illegal_code(), code_tab[cur % 10]);
        else        step(1'b1, code_tab[cur / 10], illegal_code());
      end else if (r < 24) begin
        cur = int'($urandom_range(0, 99));
        stepv(cur);
      end else if (r < 26) begin
        stepv(cur);
      end else begin
        cur = (cur + 1) % 100;
        stepv(cur);
      end
    end

    @(negedge i_clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
